floo_link_buffer: RTL and testbench



---
 rtl/floo_link_pkg.sv | 28 ++
 rtl/floo_link_buffer_sat_cnt.sv | 42 ++++
 rtl/floo_link_buffer.sv | 164 ++++++++++++++++
 tb/tb_floo_link_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/floo_link_pkg.sv
// floo_link_pkg: shared constants, types and width helpers for the FlooNoC
// inter-tile link buffer (floo_link_buffer) and its tile-level wrappers.
package floo_link_pkg;

  // Smallest depth that still gives full throughput with registered outputs.
  localparam int unsigned MinLinkDepth = 2;

  // Counter width used by tile wrappers that aggregate link statistics.
  localparam int unsigned DefaultCntWidth = 32;

  // Performance counter bundle of one link, as collected by the tile wrapper.
  typedef struct packed {
    logic [DefaultCntWidth-1:0] flits;
    logic [DefaultCntWidth-1:0] stall;
    logic [DefaultCntWidth-1:0] bp;
  } floo_link_perf_t;

  // Width of an occupancy value that must represent 0..depth inclusive.
  function automatic int unsigned floo_link_fill_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer into a buffer of the given depth (at least one bit).
  function automatic int unsigned floo_link_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/floo_link_buffer_sat_cnt.sv
// floo_link_sat_cnt: saturating event counter with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.
module floo_link_sat_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;
  logic             at_max_s;

  assign at_max_s = (cnt_q == {Width{1'b1}});

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_s) begin
      cnt_d = cnt_q + Width'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/floo_link_buffer.sv
// floo_link_buffer: elastic buffer for one FlooNoC physical link between two
// tiles. Circular buffer whose outputs come straight from registers, so the
// long inter-tile valid/ready path is cut in both directions.
// Optional feature: define FLOO_LINK_PERF_EN to build the three saturating
// performance counters (flits delivered, output stall, input back-pressure).
module floo_link_buffer
  import floo_link_pkg::*;
#(
  parameter type         flit_t   = logic,
  parameter int unsigned Depth    = MinLinkDepth,
  parameter int unsigned CntWidth = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  flit_t                      in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output flit_t                      out_data_o,
  output logic [$clog2(Depth+1)-1:0] fill_o,
  input  logic                       perf_clear_i,
  output logic [CntWidth-1:0]        perf_flits_o,
  output logic [CntWidth-1:0]        perf_stall_o,
  output logic [CntWidth-1:0]        perf_bp_o
);

  localparam int unsigned FillW = floo_link_fill_width(Depth);
  localparam int unsigned PtrW  = floo_link_ptr_width(Depth);

  localparam logic [FillW-1:0] FillMax = FillW'(Depth);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(Depth - 1);

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
  endfunction

  flit_t            mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW-1:0]  rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  wr_ptr_d;
  logic [FillW-1:0] fill_q;
  logic [FillW-1:0] fill_d;

  logic push_s;
  logic pop_s;
  logic full_s;
  logic empty_s;

  // Handshake status. in_ready only looks at our own occupancy and flush,
  // never at out_ready_i, so no combinational path crosses the buffer.
  assign full_s      = (fill_q == FillMax);
  assign empty_s     = (fill_q == '0);
  assign in_ready_o  = !full_s && !flush_i;
  assign out_valid_o = !empty_s;
  assign push_s      = in_valid_i && in_ready_o;
  assign pop_s       = out_valid_o && out_ready_i;

  // Pointer and occupancy next-state; flush returns to the empty state while a
  // same-cycle pop still counts as delivered downstream.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   fill_d = fill_q + FillW'(1);
        2'b01:   fill_d = fill_q - FillW'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Flit storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Head flit is a pure register read: no bypass from in_data_i.
  assign out_data_o = mem_q[rd_ptr_q];
  assign fill_o     = fill_q;

`ifdef FLOO_LINK_PERF_EN
  logic stall_s;
  logic bp_s;

  assign stall_s = out_valid_o && !out_ready_i;
  assign bp_s    = in_valid_i && !in_ready_o;

  floo_link_sat_cnt #(
    .Width (CntWidth)
  ) i_cnt_flits (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (perf_clear_i),
    .inc_i   (pop_s),
    .cnt_o   (perf_flits_o)
  );

  floo_link_sat_cnt #(
    .Width (CntWidth)
  ) i_cnt_stall (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (perf_clear_i),
    .inc_i   (stall_s),
    .cnt_o   (perf_stall_o)
  );

  floo_link_sat_cnt #(
    .Width (CntWidth)
  ) i_cnt_bp (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (perf_clear_i),
    .inc_i   (bp_s),
    .cnt_o   (perf_bp_o)
  );
`else
  logic unused_perf_clear_s;

  assign unused_perf_clear_s = perf_clear_i;
  assign perf_flits_o        = '0;
  assign perf_stall_o        = '0;
  assign perf_bp_o           = '0;
`endif

endmodule

// File: tb/tb_floo_link_buffer.sv
// Directed, table-driven bench for floo_link_buffer. Instance A: Depth=2,
// CntWidth=32. Instance B: Depth=3, CntWidth=4 (pointer wrap, saturation).
module tb_floo_link_buffer;

  typedef logic [7:0] flit_t;

`ifdef FLOO_LINK_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  typedef struct {
    logic       iv;
    flit_t      d;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    flit_t      e_od;
    logic [1:0] e_fill;
  } vec_t;

  logic clk;
  logic rst_n;

  logic        a_flush, a_iv, a_ir, a_ov, a_or, a_clr;
  flit_t       a_id, a_od;
  logic [1:0]  a_fill;
  logic [31:0] a_pf, a_ps, a_pb;

  logic        b_flush, b_iv, b_ir, b_ov, b_or, b_clr;
  flit_t       b_id, b_od;
  logic [1:0]  b_fill;
  logic [3:0]  b_pf, b_ps, b_pb;

  int tests;
  int fails;
  vec_t vecs [15];

  floo_link_buffer #(.flit_t(flit_t), .Depth(2), .CntWidth(32)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od),
    .fill_o(a_fill), .perf_clear_i(a_clr),
    .perf_flits_o(a_pf), .perf_stall_o(a_ps), .perf_bp_o(a_pb)
  );

  floo_link_buffer #(.flit_t(flit_t), .Depth(3), .CntWidth(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od),
    .fill_o(b_fill), .perf_clear_i(b_clr),
    .perf_flits_o(b_pf), .perf_stall_o(b_ps), .perf_bp_o(b_pb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input flit_t d, input logic ordy, input logic fl,
                              input logic e_ir, input logic e_ov, input flit_t e_od,
                              input logic [1:0] e_fill);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_fill = e_fill;
    return v;
  endfunction

  function automatic logic [31:0] pexp(input logic [31:0] v);
    return PerfOn ? v : 32'd0;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_clr = 1'b0; a_id = 8'h00;
    b_flush = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_clr = 1'b0; b_id = 8'h00;

    //            iv    d      ordy  fl    | ir    ov    od     fill
    vecs[0]  = mk(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
    vecs[1]  = mk(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 2'd1);
    vecs[2]  = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2);
    vecs[3]  = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2);
    vecs[4]  = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2);
    vecs[5]  = mk(1'b0, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2);
    vecs[6]  = mk(1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1);
    vecs[7]  = mk(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2'd1);
    vecs[8]  = mk(1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 2'd1);
    vecs[9]  = mk(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 2'd2);
    vecs[10] = mk(1'b1, 8'hA6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
    vecs[11] = mk(1'b0, 8'hA6, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA6, 2'd1);
    vecs[12] = mk(1'b1, 8'hA7, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
    vecs[13] = mk(1'b0, 8'hA7, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA7, 2'd1);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);

    // Reset values
    #1;
    chk("rst a_ov", 32'(a_ov), 32'd0);
    chk("rst a_ir", 32'(a_ir), 32'd1);
    chk("rst a_fill", 32'(a_fill), 32'd0);
    chk("rst a_od", 32'(a_od), 32'd0);
    chk("rst a_pf", a_pf, 32'd0);
    chk("rst b_ov", 32'(b_ov), 32'd0);
    chk("rst b_ir", 32'(b_ir), 32'd1);
    chk("rst b_ps", 32'(b_ps), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-pressure, full, simultaneous push/pop and flush on instance A
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      a_iv = vecs[i].iv; a_id = vecs[i].d; a_or = vecs[i].ordy; a_flush = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(a_ir), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d out_valid", i), 32'(a_ov), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d fill", i), 32'(a_fill), 32'(vecs[i].e_fill));
      if (vecs[i].e_ov) chk($sformatf("vec%0d out_data", i), 32'(a_od), 32'(vecs[i].e_od));
    end
    @(negedge clk);
    a_iv = 1'b0; a_or = 1'b0; a_flush = 1'b0; a_clr = 1'b1;
    #1;
    chk("vec perf_flits", a_pf, pexp(32'd5));
    chk("vec perf_stall", a_ps, pexp(32'd6));
    chk("vec perf_bp", a_pb, pexp(32'd4));
    @(negedge clk);
    a_clr = 1'b0;
    #1;
    chk("clr perf_flits", a_pf, 32'd0);
    chk("clr perf_stall", a_ps, 32'd0);
    chk("clr perf_bp", a_pb, 32'd0);

    // Streaming 100 flits through instance A
    for (int c = 0; c < 102; c++) begin
      @(negedge clk);
      a_iv = (c < 100); a_id = flit_t'(c); a_or = 1'b1;
      #1;
      chk($sformatf("strm%0d in_ready", c), 32'(a_ir), 32'd1);
      if (c >= 1 && c <= 100) begin
        chk($sformatf("strm%0d out_valid", c), 32'(a_ov), 32'd1);
        chk($sformatf("strm%0d out_data", c), 32'(a_od), 32'(c - 1));
      end else begin
        chk($sformatf("strm%0d out_valid", c), 32'(a_ov), 32'd0);
      end
    end
    chk("strm perf_flits", a_pf, pexp(32'd100));
    chk("strm perf_stall", a_ps, 32'd0);

    // Push/pop at fill=1 across pointer wrap on instance B (Depth=3)
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      b_iv = (c < 10); b_id = flit_t'(8'h50 + c); b_or = 1'b1;
      #1;
      if (c >= 1 && c <= 10) begin
        chk($sformatf("wrap%0d fill", c), 32'(b_fill), 32'd1);
        chk($sformatf("wrap%0d out_data", c), 32'(b_od), 32'(8'h50 + c - 1));
      end else begin
        chk($sformatf("wrap%0d fill", c), 32'(b_fill), 32'd0);
      end
    end
    chk("wrap perf_flits", 32'(b_pf), pexp(32'd10));

    // Stall saturation and clear-with-stall on instance B (CntWidth=4)
    @(negedge clk);
    b_iv = 1'b1; b_id = 8'h77; b_or = 1'b0;
    @(negedge clk);
    b_iv = 1'b0;
    repeat (19) @(negedge clk);
    #1;
    chk("sat out_data stable", 32'(b_od), 32'h77);
    chk("sat fill", 32'(b_fill), 32'd1);
    @(negedge clk);
    b_clr = 1'b1;
    #1;
    chk("sat perf_stall", 32'(b_ps), pexp(32'd15));
    @(negedge clk);
    b_clr = 1'b0;
    #1;
    chk("clr-wins perf_stall", 32'(b_ps), 32'd0);
    chk("clr-wins perf_flits", 32'(b_pf), 32'd0);
    @(negedge clk);
    b_or = 1'b1;
    #1;
    chk("post-clr perf_stall", 32'(b_ps), pexp(32'd1));
    chk("drain out_data", 32'(b_od), 32'h77);
    @(negedge clk);
    b_or = 1'b0;
    #1;
    chk("drain out_valid", 32'(b_ov), 32'd0);

    // Reset mid-stream with fill=2 on instance A
    @(negedge clk);
    a_iv = 1'b1; a_id = 8'hC1; a_or = 1'b0;
    @(negedge clk);
    a_id = 8'hC2;
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    chk("mid fill", 32'(a_fill), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", 32'(a_ov), 32'd0);
    chk("mid-rst in_ready", 32'(a_ir), 32'd1);
    chk("mid-rst fill", 32'(a_fill), 32'd0);
    chk("mid-rst out_data", 32'(a_od), 32'd0);
    chk("mid-rst perf_stall", a_ps, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_iv = 1'b1; a_id = 8'hD1; a_or = 1'b1;
    #1;
    chk("fresh out_valid0", 32'(a_ov), 32'd0);
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    chk("fresh out_valid1", 32'(a_ov), 32'd1);
    chk("fresh out_data", 32'(a_od), 32'hD1);
    chk("fresh fill", 32'(a_fill), 32'd1);
    @(negedge clk);
    #1;
    chk("fresh drained", 32'(a_ov), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
